// File: rtl/button_cmd_conditioner.sv
// Push-button command front end: two-flop synchronizers, per-button debounce,
// rising-edge capture into a pending set, and prioritized, gap-spaced issue.

module bcc_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sync,
    output logic o_stable,
    output logic o_rise
);
    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;
    logic             r_stable_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
        end else begin
            r_stable_d <= r_stable;
            if (i_sync == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                // this increment would reach DEBOUNCE_CYCLES: accept the new level
                r_stable <= ~r_stable;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = r_stable & ~r_stable_d;
endmodule

module button_cmd_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18,     // 2**CNT_W must exceed DEBOUNCE_CYCLES
    parameter int GAP             = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] btn_raw,
    input  logic [7:0] sw_raw,
    output logic [2:0] btn,
    output logic [7:0] bytePos,
    output logic [2:0] pending
);
    localparam int NUM_BTN = 3;
    localparam int SW_W    = 8;
    localparam int GAP_W   = (GAP > 0) ? $clog2(GAP + 1) : 1;

    logic [NUM_BTN-1:0] r_btn_meta, r_btn_s;
    logic [SW_W-1:0]    r_sw_meta, r_sw_s;
    logic [NUM_BTN-1:0] w_stable, w_rise;
    logic [NUM_BTN-1:0] w_sel, w_clr;
    logic               w_issue;
    logic [NUM_BTN-1:0] r_pending, r_btn;
    logic [SW_W-1:0]    r_pos;
    logic [GAP_W-1:0]   r_gap;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_btn_meta <= '0;
            r_btn_s    <= '0;
            r_sw_meta  <= '0;
            r_sw_s     <= '0;
        end else begin
            r_btn_meta <= btn_raw;
            r_btn_s    <= r_btn_meta;
            r_sw_meta  <= sw_raw;
            r_sw_s     <= r_sw_meta;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_db
            bcc_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_db (
                .clk     (clk),
                .rst     (rst),
                .i_sync  (r_btn_s[gi]),
                .o_stable(w_stable[gi]),
                .o_rise  (w_rise[gi])
            );
        end
    endgenerate

    // highest button index wins when several are pending
    always_comb begin
        w_sel = '0;
        if (r_pending[2])      w_sel = 3'b100;
        else if (r_pending[1]) w_sel = 3'b010;
        else if (r_pending[0]) w_sel = 3'b001;
    end

    assign w_issue = (r_gap == '0) && (r_pending != '0);
    assign w_clr   = w_issue ? w_sel : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= '0;
            r_btn     <= '0;
            r_pos     <= '0;
            r_gap     <= '0;
        end else begin
            // a new press landing on the bit being issued survives
            r_pending <= (r_pending & ~w_clr) | w_rise;
            if (w_issue) begin
                r_btn <= w_sel;
                r_pos <= r_sw_s;
                r_gap <= GAP_W'(GAP);
            end else begin
                r_btn <= '0;
                if (r_gap != '0) r_gap <= r_gap - 1'b1;
            end
        end
    end

    assign btn     = r_btn;
    assign bytePos = r_pos;
    assign pending = r_pending;
endmodule

// File: tb/tb_button_cmd_conditioner.sv
// Directed vector bench for button_cmd_conditioner at DEBOUNCE_CYCLES=4, GAP=2.

module tb_button_cmd_conditioner;
    localparam int D  = 4;
    localparam int CW = 3;
    localparam int G  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] btn_raw;
    logic [7:0] sw_raw;
    logic [2:0] btn;
    logic [7:0] bytePos;
    logic [2:0] pending;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] braw;
        logic [7:0] sw;
        logic [2:0] eb;
        logic [2:0] ep;
        logic [7:0] epos;
    } vec_t;

    vec_t vecs[$];

    button_cmd_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (CW),
        .GAP            (G)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_raw),
        .sw_raw (sw_raw),
        .btn    (btn),
        .bytePos(bytePos),
        .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic add(input logic [2:0] braw, input logic [7:0] sw,
                       input logic [2:0] eb, input logic [2:0] ep, input logic [7:0] epos);
        vec_t v;
        v.braw = braw; v.sw = sw; v.eb = eb; v.ep = ep; v.epos = epos;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    initial begin
        bit found;

        // idle after reset
        for (int s = 1; s <= 20; s++) add(3'b000, 8'h00, 3'b000, 3'b000, 8'h00);
        // single press of button 2, issue after edge 8
        for (int s = 1; s <= 20; s++)
            add(3'b100, 8'h50, (s == 8) ? 3'b100 : 3'b000, (s == 7) ? 3'b100 : 3'b000,
                (s >= 8) ? 8'h50 : 8'h00);
        for (int s = 1; s <= 12; s++) add(3'b000, 8'h50, 3'b000, 3'b000, 8'h50);
        // 3-cycle glitch on button 0 is rejected
        for (int s = 1; s <= 3; s++)  add(3'b001, 8'h50, 3'b000, 3'b000, 8'h50);
        for (int s = 1; s <= 10; s++) add(3'b000, 8'h50, 3'b000, 3'b000, 8'h50);
        // exactly 4-cycle press on button 1 is accepted
        for (int s = 1; s <= 16; s++)
            add((s <= 4) ? 3'b010 : 3'b000, 8'h5A, (s == 8) ? 3'b010 : 3'b000,
                (s == 7) ? 3'b010 : 3'b000, (s >= 8) ? 8'h5A : 8'h50);
        // simultaneous press, switches change after the first issue
        for (int s = 1; s <= 24; s++) begin
            logic [2:0] eb, ep;
            logic [7:0] epos;
            eb = (s == 8) ? 3'b100 : (s == 11) ? 3'b010 : (s == 14) ? 3'b001 : 3'b000;
            ep = (s < 7) ? 3'b000 : (s == 7) ? 3'b111 : (s <= 10) ? 3'b011 :
                 (s <= 13) ? 3'b001 : 3'b000;
            epos = (s < 8) ? 8'h5A : (s <= 10) ? 8'h0A : 8'h33;
            add((s <= 10) ? 3'b111 : 3'b000, (s <= 8) ? 8'h0A : 8'h33, eb, ep, epos);
        end

        rst = 1'b1; btn_raw = '0; sw_raw = '0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("async_rst btn", {5'd0, btn}, 8'h00);
        chk("async_rst pending", {5'd0, pending}, 8'h00);
        chk("async_rst bytePos", bytePos, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            btn_raw = vecs[i].braw;
            sw_raw  = vecs[i].sw;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d btn", i), {5'd0, btn}, {5'd0, vecs[i].eb});
            chk($sformatf("v%0d pending", i), {5'd0, pending}, {5'd0, vecs[i].ep});
            chk($sformatf("v%0d bytePos", i), bytePos, vecs[i].epos);
        end

        // reset while two presses are queued
        btn_raw = 3'b011;
        sw_raw  = 8'h77;
        found   = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (pending == 3'b011) found = 1'b1;
        end
        chk("midrst reach pending=011", {7'd0, found}, 8'h01);
        rst = 1'b0;
        #1;
        chk("midrst pending", {5'd0, pending}, 8'h00);
        chk("midrst btn", {5'd0, btn}, 8'h00);
        chk("midrst bytePos", bytePos, 8'h00);
        btn_raw = 3'b000;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("post_rst c%0d btn", c), {5'd0, btn}, 8'h00);
            chk($sformatf("post_rst c%0d pending", c), {5'd0, pending}, 8'h00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/button_cmd_conditioner.md
Name: button_cmd_conditioner

Overview:
- Upstream front end for the processor's command inputs.
- Takes three raw push-buttons and an 8-bit switch bank from the board. Synchronizes and debounces each button and converts each debounced press into one single-cycle one-hot command on btn.
- Presents bytePos, sampled from the switches, in the same cycle as the command.
- Queues simultaneous presses and issues them one at a time, with a minimum spacing, so the processor never sees two commands in one cycle.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive cycles a synchronized button must differ from its stable state before the stable state flips (5 ms at 50 MHz).
CNT_W, 18, width of each debounce counter; must satisfy 2**CNT_W > DEBOUNCE_CYCLES.
GAP, 2, idle cycles forced on btn after each issued command (0 = back-to-back allowed).

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
btn_raw  input  3  raw push-buttons, active-high, asynchronous to clk
sw_raw  input  8  raw switch bank, asynchronous to clk
btn  output  3  one-hot command pulse, one cycle wide (001, 010, 100) or 000
bytePos  output  8  switch value captured with the most recent command
pending  output  3  debounced presses not yet issued (status/debug)

Behaviour:
- Reset (rst=0, asynchronous): btn=000, bytePos=00, pending=000. Sync flops, stable states and counters are cleared, and the gap counter is 0. Any press in progress is discarded, with no pulse after release of reset.
- Synchronization: btn_raw and sw_raw each pass through 2 flip-flops. Only the second stage (btn_s, sw_s) is used downstream.
- Debounce, per button i:
  - Counter clears on any cycle where btn_s[i] == stable[i].
  - Otherwise the counter increments.
  - When the increment would reach DEBOUNCE_CYCLES, stable[i] toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never toggles stable.
- Edge detect: a 0->1 transition of stable[i] sets pending[i] on the next edge. A release (1->0) produces nothing.
- Issue logic: a command is issued on an edge where gap counter == 0 and pending != 000.
  - btn <= the one-hot of the highest-priority pending bit, priority bit 2 > bit 1 > bit 0.
  - bytePos <= sw_s.
  - That pending bit clears.
  - The gap counter loads GAP.
- On all other edges: btn <= 000, bytePos holds, and the gap counter decrements if nonzero.
- btn is never high for two consecutive cycles unless GAP=0, and is never multi-hot.
- Simultaneous set and clear of the same pending bit on one edge: set wins, so the bit stays 1.
- Latency: number the first clk edge that samples btn_raw[i]=1 as edge 1, with the input held stable and nothing else pending. stable toggles at edge D+2, pending[i] sets at edge D+3, and btn goes high after edge D+4 for exactly one cycle (D = DEBOUNCE_CYCLES).
- Holding a button continuously produces exactly one command. A re-press requires a debounced release first.
- sw_raw changes between commands do not affect bytePos until the next issue.

Test Plan (DEBOUNCE_CYCLES=4, GAP=2):
1. Reset and idle: assert rst=0 mid-cycle -> btn=000, bytePos=00, pending=000 immediately without waiting for a clock. Release rst with all inputs 0, run 20 cycles -> outputs unchanged.
2. Single press: sw_raw=50, hold btn_raw=100 for 20 cycles -> btn=100 for exactly one cycle, after edge 8 counted from the first edge sampling the press; bytePos=50 from that cycle on. No further pulse while held or on release.
3. Glitch rejection: btn_raw[0] high for 3 cycles then low -> btn stays 000 and pending stays 000 throughout.
4. Simultaneous press: btn_raw=111 held for 10 cycles with sw_raw=0x0A -> pending=111, then btn sequence 100, 000, 000, 010, 000, 000, 001 on consecutive cycles, with bytePos=0x0A on each issue.
5. Switch change mid-queue: during scenario 4, change sw_raw to 0x33 after the first issue -> later issues capture 0x33, respecting the 2-cycle sync delay.
6. Reset mid-operation: rst=0 while pending=011 -> pending=000 and btn=000. After rst=1 with buttons released -> no command is ever issued.
